// File: rtl/ysyx_22050612_arb_pkg.sv
// Shared types and defaults for the IFU/LSU memory-port arbiter.
package ysyx_22050612_arb_pkg;

  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IFU  = 2'd1,
    OWN_LSU  = 2'd2
  } arb_owner_e;

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] lim);
    return (v >= lim) ? lim : v + 8'd1;
  endfunction

endpackage

// File: rtl/ysyx_22050612_arb_prio.sv
// LSU-first grant select with a saturating starvation counter that forces the IFU through.
module ysyx_22050612_arb_prio
  import ysyx_22050612_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_valid_i,
  input  logic ls_valid_i,
  input  logic fire_i,
  output logic grant_if_o,
  output logic grant_ls_o
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] starve_cnt_q, starve_cnt_d;
  logic       if_forced;

  assign if_forced  = if_valid_i && (starve_cnt_q == LIMIT);
  assign grant_ls_o = ls_valid_i && !if_forced;
  assign grant_if_o = if_valid_i && !grant_ls_o;

  // Only contested LSU wins count towards starvation.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (fire_i) begin
      if (grant_if_o) begin
        starve_cnt_d = 8'd0;
      end else if (grant_ls_o && if_valid_i) begin
        starve_cnt_d = sat_inc(starve_cnt_q, LIMIT);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt_q <= 8'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/ysyx_22050612_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between IFU and LSU.
// Optional perf counters are enabled with ARB_PERF_CNT_EN.
// Handshakes: a request transfers on a rising edge where valid && ready are both 1;
// requesters hold valid and fields until then. Responses are single-cycle pulses.
module ysyx_22050612_mem_arbiter
  import ysyx_22050612_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic                ls_wen,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wmask,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [1:0]          dbg_state_o
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [63:0]         perf_if_grants,
  output logic [63:0]         perf_ls_grants,
  output logic [63:0]         perf_stall_cycles
`endif
);

  localparam int MASK_W = DATA_W / 8;

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  logic              mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [MASK_W-1:0] mem_wmask_q, mem_wmask_d;
  logic              if_resp_q, if_resp_d, ls_resp_q, ls_resp_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
  logic              grant_if, grant_ls, fire, idle;

  // Readies are gated by rst_n so nothing is accepted during the reset cycle.
  assign idle         = (state_q == ST_IDLE) && rst_n;
  assign if_req_ready = idle && grant_if;
  assign ls_req_ready = idle && grant_ls;
  assign fire         = if_req_ready || ls_req_ready;

  ysyx_22050612_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_valid_i (if_req_valid),
    .ls_valid_i (ls_req_valid),
    .fire_i     (fire),
    .grant_if_o (grant_if),
    .grant_ls_o (grant_ls)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_wen_d   = mem_wen_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    if_resp_d   = 1'b0;
    ls_resp_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (ls_req_ready) begin
          mem_wen_d   = ls_wen;
          mem_addr_d  = ls_addr;
          mem_wdata_d = ls_wdata;
          mem_wmask_d = ls_wmask;
          owner_d     = OWN_LSU;
          state_d     = ST_REQ;
        end else if (if_req_ready) begin
          mem_wen_d   = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_wmask_d = '0;
          owner_d     = OWN_IFU;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_resp_valid) begin
          state_d = ST_IDLE;
          owner_d = OWN_NONE;
          if (owner_q == OWN_IFU) begin
            if_resp_d  = 1'b1;
            if_rdata_d = mem_rdata;
          end else if (owner_q == OWN_LSU) begin
            ls_resp_d  = 1'b1;
            ls_rdata_d = mem_wen_q ? '0 : mem_rdata;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_NONE;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      if_resp_q   <= 1'b0;
      ls_resp_q   <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      if_resp_q   <= if_resp_d;
      ls_resp_q   <= ls_resp_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  assign mem_req_valid = (state_q == ST_REQ);
  assign mem_wen       = mem_wen_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wmask     = mem_wmask_q;
  assign if_resp_valid = if_resp_q;
  assign ls_resp_valid = ls_resp_q;
  assign if_rdata      = if_rdata_q;
  assign ls_rdata      = ls_rdata_q;
  assign dbg_state_o   = state_q;

`ifdef ARB_PERF_CNT_EN
  logic [63:0] perf_if_q, perf_ls_q, perf_stall_q;
  logic        stall;

  // A cycle counts once even when both requesters are stalled.
  assign stall = (if_req_valid && !if_req_ready) || (ls_req_valid && !ls_req_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_if_q    <= 64'd0;
      perf_ls_q    <= 64'd0;
      perf_stall_q <= 64'd0;
    end else begin
      if (if_req_ready) perf_if_q <= perf_if_q + 64'd1;
      if (ls_req_ready) perf_ls_q <= perf_ls_q + 64'd1;
      if (stall)        perf_stall_q <= perf_stall_q + 64'd1;
    end
  end

  assign perf_if_grants    = perf_if_q;
  assign perf_ls_grants    = perf_ls_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_ysyx_22050612_mem_arbiter.sv
// Scoreboard bench for the memory arbiter: directed requests, a memory responder, one monitor.
module tb_ysyx_22050612_mem_arbiter;

  typedef struct packed {
    logic        wen;
    logic [63:0] addr;
    logic [7:0]  wmask;
    logic [63:0] wdata;
  } mem_req_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_valid, if_req_ready, if_resp_valid;
  logic [63:0] if_addr, if_rdata;
  logic        ls_req_valid, ls_req_ready, ls_wen, ls_resp_valid;
  logic [63:0] ls_addr, ls_wdata, ls_rdata;
  logic [7:0]  ls_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  logic [1:0]  dbg_state;
`ifdef ARB_PERF_CNT_EN
  logic [63:0] perf_if_grants, perf_ls_grants, perf_stall_cycles;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int last_ls_resp_cyc = -1;
  int stall_cnt = 0;
  int stall_left = 0;
  bit resp_enable = 1'b1;
  bit stray = 1'b0;
  bit check_lat = 1'b1;
  bit chk2 = 1'b0;
  bit mem_first = 1'b0;
  bit pend = 1'b0;
  logic [63:0] pend_addr;

  logic [63:0] exp_if_q[$];
  logic [63:0] exp_ls_q[$];
  logic [1:0]  exp_grant_q[$];
  mem_req_t    exp_mem_q[$];

  ysyx_22050612_mem_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_req_valid   (if_req_valid),
    .if_req_ready   (if_req_ready),
    .if_addr        (if_addr),
    .if_resp_valid  (if_resp_valid),
    .if_rdata       (if_rdata),
    .ls_req_valid   (ls_req_valid),
    .ls_req_ready   (ls_req_ready),
    .ls_wen         (ls_wen),
    .ls_addr        (ls_addr),
    .ls_wdata       (ls_wdata),
    .ls_wmask       (ls_wmask),
    .ls_resp_valid  (ls_resp_valid),
    .ls_rdata       (ls_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_wen        (mem_wen),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata),
    .dbg_state_o    (dbg_state)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_if_grants    (perf_if_grants),
    .perf_ls_grants    (perf_ls_grants),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  // Clock and reset-independent cycle counter
  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] mem_model(input logic [63:0] a);
    if (a == 64'h0000_0000_8000_0000) return 64'h0010_0073_0000_0013;
    return {a[31:0] ^ 32'hA5A5_A5A5, a[31:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory responder: honours stall_left, answers one cycle after the handshake.
  initial begin
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = 64'h0;
    forever begin
      @(negedge clk);
      mem_resp_valid = (pend && resp_enable) || stray;
      mem_rdata      = pend ? mem_model(pend_addr) : 64'h0;
      pend           = 1'b0;
      #1;
      if (mem_req_valid) begin
        if (stall_left > 0) begin
          mem_req_ready = 1'b0;
          stall_left--;
        end else begin
          mem_req_ready = 1'b1;
          pend          = 1'b1;
          pend_addr     = mem_addr;
        end
      end else begin
        mem_req_ready = 1'b1;
      end
    end
  end

  // Drivers: called at a negedge, return at the negedge after the handshake with valid still high.
  task automatic if_read(input logic [63:0] a, input bit exp_resp);
    int n = 0;
    if_req_valid = 1'b1;
    if_addr      = a;
    #1;
    while (!if_req_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!if_req_ready) begin
      check("if_accept_timeout", 64'd0, 64'd1);
      if_req_valid = 1'b0;
      return;
    end
    exp_mem_q.push_back('{wen: 1'b0, addr: a, wmask: 8'h00, wdata: 64'h0});
    if (exp_resp) exp_if_q.push_back(mem_model(a));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ls_access(input logic wen, input logic [63:0] a, input logic [63:0] wd,
                           input logic [7:0] wm, input bit exp_resp);
    int n = 0;
    ls_req_valid = 1'b1;
    ls_wen       = wen;
    ls_addr      = a;
    ls_wdata     = wd;
    ls_wmask     = wm;
    #1;
    while (!ls_req_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!ls_req_ready) begin
      check("ls_accept_timeout", 64'd0, 64'd1);
      ls_req_valid = 1'b0;
      return;
    end
    exp_mem_q.push_back('{wen: wen, addr: a, wmask: wm, wdata: wd});
    if (exp_resp) exp_ls_q.push_back(wen ? 64'h0 : mem_model(a));
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor / scoreboard
  initial begin
    logic [1:0] got;
    mem_req_t   e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) continue;
      if (if_resp_valid) begin
        if (exp_if_q.size() == 0) check("if_resp_unexpected", 64'd1, 64'd0);
        else begin
          check("if_rdata", if_rdata, exp_if_q.pop_front());
          if (check_lat) check("if_resp_latency", 64'(cyc - accept_cyc), 64'd3);
        end
      end
      if (ls_resp_valid) begin
        last_ls_resp_cyc = cyc;
        if (exp_ls_q.size() == 0) check("ls_resp_unexpected", 64'd1, 64'd0);
        else begin
          check("ls_rdata", ls_rdata, exp_ls_q.pop_front());
          if (check_lat) check("ls_resp_latency", 64'(cyc - accept_cyc), 64'd3);
        end
      end
      if (if_req_ready && ls_req_ready) check("both_ready", 64'd1, 64'd0);
      if (mem_req_valid && (if_req_ready || ls_req_ready)) check("ready_outside_idle", 64'd1, 64'd0);
      got = 2'd0;
      if (if_req_valid && if_req_ready) got = 2'd1;
      else if (ls_req_valid && ls_req_ready) got = 2'd2;
      if (got != 2'd0) begin
        if (exp_grant_q.size() == 0) check("grant_unexpected", 64'(got), 64'd0);
        else check("grant_order", 64'(got), 64'(exp_grant_q.pop_front()));
        if (got == 2'd1 && chk2) check("if_accept_on_ls_resp", 64'(cyc), 64'(last_ls_resp_cyc));
        accept_cyc = cyc;
        mem_first  = 1'b1;
      end
      if (mem_req_valid) begin
        if (exp_mem_q.size() == 0) check("mem_req_unexpected", 64'd1, 64'd0);
        else begin
          e = exp_mem_q[0];
          check("mem_addr", mem_addr, e.addr);
          check("mem_wen", 64'(mem_wen), 64'(e.wen));
          check("mem_wmask", 64'(mem_wmask), 64'(e.wmask));
          check("mem_wdata", mem_wdata, e.wdata);
          if (mem_first) check("mem_req_latency", 64'(cyc - accept_cyc), 64'd1);
          mem_first = 1'b0;
          if (mem_req_ready) void'(exp_mem_q.pop_front());
        end
      end
      if ((if_req_valid && !if_req_ready) || (ls_req_valid && !ls_req_ready)) stall_cnt++;
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 64'(dbg_state), 64'd0);
    check({tag, "_if_ready"}, 64'(if_req_ready), 64'd0);
    check({tag, "_ls_ready"}, 64'(ls_req_ready), 64'd0);
    check({tag, "_mem_valid"}, 64'(mem_req_valid), 64'd0);
    check({tag, "_if_resp"}, 64'(if_resp_valid), 64'd0);
    check({tag, "_ls_resp"}, 64'(ls_resp_valid), 64'd0);
    check({tag, "_mem_wen"}, 64'(mem_wen), 64'd0);
    check({tag, "_mem_addr"}, mem_addr, 64'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 64'd0);
    check({tag, "_mem_wmask"}, 64'(mem_wmask), 64'd0);
    check({tag, "_if_rdata"}, if_rdata, 64'd0);
    check({tag, "_ls_rdata"}, ls_rdata, 64'd0);
`ifdef ARB_PERF_CNT_EN
    check({tag, "_perf_if"}, perf_if_grants, 64'd0);
    check({tag, "_perf_ls"}, perf_ls_grants, 64'd0);
    check({tag, "_perf_stall"}, perf_stall_cycles, 64'd0);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    if_req_valid = 1'b0; if_addr = 64'h0;
    ls_req_valid = 1'b0; ls_wen = 1'b0; ls_addr = 64'h0; ls_wdata = 64'h0; ls_wmask = 8'h0;
    repeat (3) @(negedge clk);
    #2;
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Both requesters held busy: LS x4 then IF, repeated
    for (int i = 0; i < 2; i++) begin
      repeat (4) exp_grant_q.push_back(2'd2);
      exp_grant_q.push_back(2'd1);
    end
    fork
      begin
        for (int i = 0; i < 8; i++) ls_access(1'b0, 64'h8000_2000 + 64'(8 * i), 64'h0, 8'h00, 1'b1);
        ls_req_valid = 1'b0;
      end
      begin
        if_read(64'h8000_0100, 1'b1);
        if_read(64'h8000_0108, 1'b1);
        if_req_valid = 1'b0;
      end
    join
    repeat (5) @(negedge clk);
`ifdef ARB_PERF_CNT_EN
    check("perf_ls_grants", perf_ls_grants, 64'd8);
    check("perf_if_grants", perf_if_grants, 64'd2);
    check("perf_stall_nonzero", 64'(perf_stall_cycles != 64'd0), 64'd1);
    check("perf_stall_cycles", perf_stall_cycles, 64'(stall_cnt));
`endif

    // IFU alone, minimum latency
    exp_grant_q.push_back(2'd1);
    if_read(64'h8000_0000, 1'b1);
    if_req_valid = 1'b0;
    repeat (5) @(negedge clk);

    // Simultaneous requests: LSU store first, IFU accepted on the store's response cycle
    exp_grant_q.push_back(2'd2);
    exp_grant_q.push_back(2'd1);
    chk2 = 1'b1;
    fork
      begin
        ls_access(1'b1, 64'h8000_1004, 64'hDEAD_BEEF_0000_0000, 8'hF0, 1'b1);
        ls_req_valid = 1'b0;
      end
      begin
        if_read(64'h8000_0010, 1'b1);
        if_req_valid = 1'b0;
      end
    join
    repeat (5) @(negedge clk);
    chk2 = 1'b0;

    // Downstream stalls 5 cycles in REQ while the IFU waits
    check_lat = 1'b0;
    stall_left = 5;
    exp_grant_q.push_back(2'd2);
    exp_grant_q.push_back(2'd1);
    ls_access(1'b0, 64'h8000_3000, 64'h0, 8'h00, 1'b1);
    ls_req_valid = 1'b0;
    if_read(64'h8000_0020, 1'b1);
    if_req_valid = 1'b0;
    repeat (6) @(negedge clk);
    check_lat = 1'b1;

    // Reset during WAIT, then a stray downstream response
    resp_enable = 1'b0;
    exp_grant_q.push_back(2'd1);
    if_read(64'h8000_0200, 1'b0);
    if_req_valid = 1'b0;
    @(negedge clk);
    check("wait_state_before_reset", 64'(dbg_state), 64'd2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check_reset_values("midreset");
    resp_enable = 1'b1;
    stray = 1'b1;
    @(negedge clk);
    #3;
    stray = 1'b0;
    repeat (4) @(negedge clk);
    exp_grant_q.push_back(2'd1);
    if_read(64'h8000_0300, 1'b1);
    if_req_valid = 1'b0;
    repeat (6) @(negedge clk);

    check("if_queue_drained", 64'(exp_if_q.size()), 64'd0);
    check("ls_queue_drained", 64'(exp_ls_q.size()), 64'd0);
    check("grant_queue_drained", 64'(exp_grant_q.size()), 64'd0);
    check("mem_queue_drained", 64'(exp_mem_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
